// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - instruction ROM filled from a byte stream, then served to the mips core
//
// Purpose: in LOAD, assembles big-endian 32-bit words from a valid/ready byte
// stream and writes them into a 2**ADDR_WIDTH word memory while holding the
// core in reset. After the byte flagged load_last, it moves to RUN, releases
// cpu_reset and serves zero-latency combinational instruction reads.
//
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous active-low reset
//   load_valid       load_byte valid this cycle
//   load_byte        program byte in stream order
//   load_last        final byte of the image (qualified by load_valid)
//   load_ready       byte accepted this cycle (high throughout LOAD)
//   rom_chip_enable  fetch enable from core
//   rom_addr         byte address from core PC
//   rom_data         instruction word (0 / NOP when not a valid hit)
//   cpu_reset        active-low reset to core, low while loading
//   load_done        high in RUN
//   word_count       number of words committed
//   overflow         sticky, bytes dropped because memory was full
module inst_rom_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic                  rom_chip_enable,
    input  logic [31:0]           rom_addr,
    output logic [31:0]           rom_data,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        LOAD,
        RUN
    } state_t;

    state_t state, state_next;

    logic [31:0]         mem [DEPTH];
    logic [1:0]          lane, lane_next;
    logic [31:0]         asm_word, asm_next;
    logic [31:0]         word_next;
    logic [ADDR_WIDTH:0] word_count_next;
    logic                overflow_next;
    logic                cpu_reset_next;
    logic                load_done_next;
    logic                mem_we;
    logic                full;

    assign full = (word_count == FULL_COUNT);

    // Current byte merged into the assembly register. Lanes after the current
    // one are still zero because the register is cleared on every commit, so
    // a word closed early by load_last is zero-padded for free.
    always_comb begin
        word_next = asm_word;
        case (lane)
            2'd0:    word_next[31:24] = load_byte;
            2'd1:    word_next[23:16] = load_byte;
            2'd2:    word_next[15:8]  = load_byte;
            default: word_next[7:0]   = load_byte;
        endcase
    end

    always_comb begin
        state_next      = state;
        lane_next       = lane;
        asm_next        = asm_word;
        word_count_next = word_count;
        overflow_next   = overflow;
        cpu_reset_next  = cpu_reset;
        load_done_next  = load_done;
        mem_we          = 1'b0;
        load_ready      = 1'b0;

        case (state)
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    if (full) begin
                        // Byte is dropped; word_count stays saturated.
                        overflow_next = 1'b1;
                    end else if (lane == 2'd3 || load_last) begin
                        mem_we          = 1'b1;
                        word_count_next = word_count + 1'b1;
                        lane_next       = 2'd0;
                        asm_next        = 32'h0;
                    end else begin
                        lane_next = lane + 2'd1;
                        asm_next  = word_next;
                    end
                    if (load_last) begin
                        state_next     = RUN;
                        cpu_reset_next = 1'b1;
                        load_done_next = 1'b1;
                    end
                end
            end
            default: begin
                // RUN: stream ignored until reset.
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= LOAD;
            lane       <= 2'd0;
            asm_word   <= 32'h0;
            word_count <= '0;
            overflow   <= 1'b0;
            cpu_reset  <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            state      <= state_next;
            lane       <= lane_next;
            asm_word   <= asm_next;
            word_count <= word_count_next;
            overflow   <= overflow_next;
            cpu_reset  <= cpu_reset_next;
            load_done  <= load_done_next;
        end
    end

    // Memory is deliberately not cleared by reset; stale words stay invisible
    // because reads are limited to indices below word_count.
    always_ff @(posedge clock) begin
        if (reset && mem_we) begin
            mem[word_count[ADDR_WIDTH-1:0]] <= word_next;
        end
    end

    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  rd_hit;

    assign rd_idx = rom_addr[ADDR_WIDTH+1:2];
    assign rd_hit = (state == RUN) && rom_chip_enable &&
                    (rom_addr[31:ADDR_WIDTH+2] == '0) &&
                    ({1'b0, rd_idx} < word_count);
    assign rom_data = rd_hit ? mem[rd_idx] : 32'h0;

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb/tb_inst_rom_loader.sv - scoreboard bench for inst_rom_loader
module tb_inst_rom_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    localparam int K_DATA  = 0;
    localparam int K_WC    = 1;
    localparam int K_OVF   = 2;
    localparam int K_DONE  = 3;
    localparam int K_CPU   = 4;
    localparam int K_READY = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          load_valid = 1'b0;
    logic [7:0]    load_byte = 8'h0;
    logic          load_last = 1'b0;
    logic          load_ready;
    logic          rom_chip_enable = 1'b0;
    logic [31:0]   rom_addr = 32'h0;
    logic [31:0]   rom_data;
    logic          cpu_reset;
    logic          load_done;
    logic [AW:0]   word_count;
    logic          overflow;

    inst_rom_loader #(.ADDR_WIDTH(AW)) dut (
        .clock           (clock),
        .reset           (reset),
        .load_valid      (load_valid),
        .load_byte       (load_byte),
        .load_last       (load_last),
        .load_ready      (load_ready),
        .rom_chip_enable (rom_chip_enable),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .cpu_reset       (cpu_reset),
        .load_done       (load_done),
        .word_count      (word_count),
        .overflow        (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] m_mem[$];
    int          m_wc;
    logic        m_ovf;

    task automatic build_model(input logic [7:0] bytes[$]);
        m_mem = {};
        m_ovf = 1'b0;
        for (int i = 0; i < bytes.size(); i++) begin
            int w;
            w = i / 4;
            if (w >= DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                if (w == m_mem.size()) m_mem.push_back(32'h0);
                m_mem[w] = m_mem[w] | (32'(bytes[i]) << (8 * (3 - (i % 4))));
            end
        end
        m_wc = m_mem.size();
    endtask

    task automatic expect_val(input int kind, input logic [31:0] v);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            while (exp_q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                string       nm;
                e = exp_q.pop_front();
                case (e.kind)
                    K_DATA:  begin act = rom_data;          nm = "rom_data";   end
                    K_WC:    begin act = 32'(word_count);   nm = "word_count"; end
                    K_OVF:   begin act = 32'(overflow);     nm = "overflow";   end
                    K_DONE:  begin act = 32'(load_done);    nm = "load_done";  end
                    K_CPU:   begin act = 32'(cpu_reset);    nm = "cpu_reset";  end
                    default: begin act = 32'(load_ready);   nm = "load_ready"; end
                endcase
                n_checks++;
                if (act === e.exp) n_pass++;
                else $display("FAIL %s addr=%h actual=%h expected=%h t=%0t",
                              nm, rom_addr, act, e.exp, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_state();
        n_checks++;
        if (word_count === '0 && overflow === 1'b0 && load_done === 1'b0 &&
            cpu_reset === 1'b0 && load_ready === 1'b1) begin
            n_pass++;
        end else begin
            $display("FAIL reset state wc=%h ovf=%b done=%b cpu=%b ready=%b t=%0t",
                     word_count, overflow, load_done, cpu_reset, load_ready, $time);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (load_done !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        n_checks++;
        if (load_done === 1'b1) n_pass++;
        else $display("FAIL timeout waiting for load_done t=%0t", $time);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        load_valid = 1'b0;
        load_last = 1'b0;
        tick();
        check_reset_state();
        reset = 1'b1;
        rom_chip_enable = 1'b1;
        rom_addr = 32'h0;
        expect_val(K_WC, 32'h0);
        expect_val(K_OVF, 32'h0);
        expect_val(K_DONE, 32'h0);
        expect_val(K_CPU, 32'h0);
        expect_val(K_READY, 32'h1);
        expect_val(K_DATA, 32'h0);
        tick();
    endtask

    task automatic load_stream(input logic [7:0] bytes[$], input bit with_last, input bit gaps);
        for (int i = 0; i < bytes.size(); i++) begin
            if (gaps) begin
                load_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            load_valid = 1'b1;
            load_byte  = bytes[i];
            load_last  = with_last && (i == bytes.size() - 1);
            expect_val(K_READY, 32'h1);
            expect_val(K_CPU, 32'h0);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic check_run();
        wait_done();
        expect_val(K_WC, 32'(m_wc));
        expect_val(K_OVF, 32'(m_ovf));
        expect_val(K_DONE, 32'h1);
        expect_val(K_CPU, 32'h1);
        expect_val(K_READY, 32'h0);
        tick();
        rom_chip_enable = 1'b1;
        for (int idx = 0; idx <= DEPTH; idx++) begin
            rom_addr = 32'(idx * 4) + 32'($urandom_range(0, 3));
            expect_val(K_DATA, (idx < m_wc) ? m_mem[idx] : 32'h0);
            tick();
        end
        rom_addr = 32'h0;
        rom_chip_enable = 1'b0;
        expect_val(K_DATA, 32'h0);
        tick();
        rom_chip_enable = 1'b1;
        rom_addr = 32'h0000_1000;
        expect_val(K_DATA, 32'h0);
        tick();
        rom_addr = 32'h8000_0000;
        expect_val(K_DATA, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_byte  = 8'($urandom);
            load_last  = 1'($urandom);
            expect_val(K_READY, 32'h0);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        rom_addr = 32'h0;
        expect_val(K_WC, 32'(m_wc));
        expect_val(K_DATA, (m_wc > 0) ? m_mem[0] : 32'h0);
        tick();
    endtask

    task automatic run_case(input logic [7:0] bytes[$], input bit gaps);
        do_reset();
        build_model(bytes);
        load_stream(bytes, 1'b1, gaps);
        check_run();
    endtask

    initial begin
        logic [7:0] b[$];
        tick();

        b = '{8'h34, 8'h01, 8'h00, 8'h20, 8'h34, 8'h02, 8'h00, 8'h30};
        run_case(b, 1'b0);
        run_case(b, 1'b1);

        b = '{8'hAB, 8'hCD};
        run_case(b, 1'b1);

        b = {};
        for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
        run_case(b, 1'b0);

        b = {};
        for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
        run_case(b, 1'b1);

        for (int it = 0; it < 8; it++) begin
            b = {};
            for (int i = 0; i < int'($urandom_range(1, 22)); i++) b.push_back(8'($urandom));
            run_case(b, 1'($urandom));
        end

        do_reset();
        b = {};
        for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
        load_stream(b, 1'b0, 1'b1);
        expect_val(K_CPU, 32'h0);
        expect_val(K_WC, 32'h1);
        tick();
        do_reset();
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        build_model(b);
        load_stream(b, 1'b1, 1'b1);
        check_run();

        reset = 1'b0;
        tick();
        reset = 1'b1;
        expect_val(K_CPU, 32'h0);
        expect_val(K_DONE, 32'h0);
        expect_val(K_READY, 32'h1);
        tick();

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
